// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small FIFO feeds a start/data/parity/stop serialiser.
// A character accepted into an empty idle block drives the start bit from the next edge; frames chain with no idle gap.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_tx_dv,
  input  logic [DATA_BITS-1:0]          i_tx_data,
  output logic                          o_tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_tx_serial,
  output logic                          o_tx_act,
  output logic                          o_tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 bit_end;
  logic                 last_stop;

  sync_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .push     (i_tx_dv),
    .push_dat (i_tx_data),
    .pop      (pop),
    .head     (head),
    .level    (o_fifo_level),
    .full     (full),
    .empty    (empty)
  );

  assign o_tx_ready = !full;
  assign bit_end    = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_stop  = (bit_idx == BW'(STOP_BITS - 1));
  // Load the next character either from idle or on the final stop clock, so frames abut.
  assign pop        = !empty && ((state == IDLE) || (state == STOP && bit_end && last_stop));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      o_tx_serial <= 1'b1;
      o_tx_act    <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      if (state != IDLE) clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
      if (pop) begin
        shreg       <= head;
        par_bit     <= (^head) ^ 1'(PARITY_ODD);
        o_tx_serial <= 1'b0;
        o_tx_act    <= 1'b1;
        state       <= START;
      end
      unique case (state)
        IDLE: ;
        START: if (bit_end) begin
          state       <= DATA;
          bit_idx     <= '0;
          o_tx_serial <= shreg[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            bit_idx <= '0;
            if (PARITY_EN != 0) begin
              state       <= PARITY;
              o_tx_serial <= par_bit;
            end else begin
              state       <= STOP;
              o_tx_serial <= 1'b1;
            end
          end else begin
            bit_idx     <= bit_idx + 1'b1;
            shreg       <= shreg >> 1;
            o_tx_serial <= shreg[1];
          end
        end
        PARITY: if (bit_end) begin
          state       <= STOP;
          o_tx_serial <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (last_stop) begin
            o_tx_done <= 1'b1;
            if (empty) begin
              state    <= IDLE;
              o_tx_act <= 1'b0;
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Two UART configurations (8N1, and 7-bit odd parity with 2 stop bits) driven with random and directed writes;
// a monitor decodes each line cycle by cycle against frames built from the accepted characters.

module tb_uart_tx_fifo;
  localparam int CPB0 = 4, DB0 = 8, PE0 = 0, PO0 = 0, SB0 = 1;
  localparam int CPB1 = 3, DB1 = 7, PE1 = 1, PO1 = 1, SB1 = 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic [8:0] d;
    int         n;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] dv = '0;
  logic [7:0] dat0 = '0;
  logic [6:0] dat1 = '0;
  logic [1:0] serial, act, done, ready;
  logic [2:0] level0, level1;

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  item_t      sbq0[$];
  item_t      sbq1[$];
  logic [8:0] l0[$];
  logic [8:0] l1[$];
  int         pos [2];
  int         start_c [2];
  int         t_free [2];
  int         done_due [2];
  int         acc_total [2];
  int         started [2];
  logic [15:0] bits [2];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB0), .DATA_BITS(DB0), .PARITY_EN(PE0), .PARITY_ODD(PO0),
                 .STOP_BITS(SB0), .FIFO_DEPTH(DEPTH)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv[0]), .i_tx_data(dat0), .o_tx_ready(ready[0]),
    .o_fifo_level(level0), .o_tx_serial(serial[0]), .o_tx_act(act[0]), .o_tx_done(done[0]));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB1), .DATA_BITS(DB1), .PARITY_EN(PE1), .PARITY_ODD(PO1),
                 .STOP_BITS(SB1), .FIFO_DEPTH(DEPTH)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv[1]), .i_tx_data(dat1), .o_tx_ready(ready[1]),
    .o_fifo_level(level1), .o_tx_serial(serial[1]), .o_tx_act(act[1]), .o_tx_done(done[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cpb(input int d);
    return (d == 0) ? CPB0 : CPB1;
  endfunction

  function automatic int nbits(input int d);
    return (d == 0) ? (1 + DB0 + PE0 + SB0) : (1 + DB1 + PE1 + SB1);
  endfunction

  // Line level for each bit slot of a frame: start, data LSB first, parity, stops.
  function automatic logic [15:0] frame_of(input int d, input logic [8:0] v);
    int db;
    int pe;
    logic p;
    logic [15:0] f;
    db = (d == 0) ? DB0 : DB1;
    pe = (d == 0) ? PE0 : PE1;
    p  = (((d == 0) ? PO0 : PO1) != 0);
    f  = '1;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[1+i] = v[i];
      p ^= v[i];
    end
    if (pe != 0) f[1+db] = p;
    return f;
  endfunction

  task automatic check(input string name, input int d, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cyc, got, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? sbq0.size() : sbq1.size();
  endfunction

  task automatic clear_model();
    sbq0.delete();
    sbq1.delete();
    for (int d = 0; d < 2; d++) begin
      pos[d] = -1; start_c[d] = 0; t_free[d] = 0; done_due[d] = -1;
      acc_total[d] = 0; started[d] = 0; bits[d] = '1;
    end
  endtask

  task automatic mon(input int d);
    item_t it;
    int    exp_s;
    int    c;
    int    f_len;
    int    lvl;
    logic  due;
    logic  inf;
    c = cpb(d);
    f_len = c * nbits(d);
    exp_s = -1;
    if (qsize(d) != 0) begin
      it = (d == 0) ? sbq0[0] : sbq1[0];
      exp_s = (it.n + 1 > t_free[d]) ? it.n + 1 : t_free[d];
    end
    if (pos[d] < 0) begin
      due = (qsize(d) != 0) && (cyc >= exp_s);
      if (serial[d] == 1'b0 || due) begin
        check("start_bit", d, int'(serial[d]), 0);
        check("start_cycle", d, cyc, exp_s);
        if (qsize(d) != 0) begin
          if (d == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
          bits[d] = frame_of(d, it.d);
        end else begin
          bits[d] = frame_of(d, 9'h000);
        end
        pos[d] = 0;
        start_c[d] = cyc;
        started[d]++;
      end
    end
    inf = (pos[d] >= 0);
    if (inf) begin
      check("serial_bit", d, int'(serial[d]), int'(bits[d][pos[d] / c]));
      pos[d]++;
      if (pos[d] == f_len) begin
        pos[d] = -1;
        t_free[d] = start_c[d] + f_len;
        done_due[d] = start_c[d] + f_len;
      end
    end else begin
      check("idle_line", d, int'(serial[d]), 1);
    end
    check("tx_act", d, int'(act[d]), int'(inf));
    check("tx_done", d, int'(done[d]), int'(cyc == done_due[d]));
    lvl = (d == 0) ? int'(level0) : int'(level1);
    check("fifo_level", d, lvl, acc_total[d] - started[d]);
    check("tx_ready", d, int'(ready[d]), int'((acc_total[d] - started[d]) != DEPTH));
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  // Ready depends only on the registered level, so sampling it at the falling edge gives the acceptance outcome.
  task automatic drive(input logic [1:0] want, input logic [8:0] v0, input logic [8:0] v1,
                       output logic [1:0] took);
    item_t it;
    @(negedge clk);
    dv   = want;
    dat0 = v0[7:0];
    dat1 = v1[6:0];
    took = want & ready;
    if (took[0]) begin
      it.d = {1'b0, v0[7:0]}; it.n = cyc + 1;
      sbq0.push_back(it); acc_total[0]++;
    end
    if (took[1]) begin
      it.d = {2'b00, v1[6:0]}; it.n = cyc + 1;
      sbq1.push_back(it); acc_total[1]++;
    end
  endtask

  task automatic send();
    int i0;
    int i1;
    int guard;
    logic [1:0] took;
    logic [8:0] v0;
    logic [8:0] v1;
    i0 = 0; i1 = 0; guard = 0;
    while ((i0 < l0.size() || i1 < l1.size()) && guard < 2000) begin
      v0 = (i0 < l0.size()) ? l0[i0] : 9'h000;
      v1 = (i1 < l1.size()) ? l1[i1] : 9'h000;
      drive({i1 < l1.size(), i0 < l0.size()}, v0, v1, took);
      if (took[0]) i0++;
      if (took[1]) i1++;
      guard++;
    end
    check("send_budget", 0, int'(guard < 2000), 1);
    drive(2'b00, 9'h000, 9'h000, took);
    l0.delete();
    l1.delete();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sbq0.size() != 0 || sbq1.size() != 0 || pos[0] >= 0 || pos[1] >= 0 || act != 2'b00)
           && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("drain_budget", 0, int'(g < 5000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      check("rst_serial", d, int'(serial[d]), 1);
      check("rst_act", d, int'(act[d]), 0);
      check("rst_done", d, int'(done[d]), 0);
      check("rst_level", d, (d == 0) ? int'(level0) : int'(level1), 0);
      check("rst_ready", d, int'(ready[d]), 1);
    end
  endtask

  initial begin
    logic [1:0] took;
    int g;
    clear_model();
    #1 rst_n = 1'b0;
    #2 check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Isolated frames: 0xA5 on 8N1, 0x55 on 7-bit odd parity.
    l0.push_back(9'h0A5); l1.push_back(9'h055);
    send();
    wait_idle();
    l1.push_back(9'h07F);
    send();
    wait_idle();

    // Three characters on consecutive cycles go out back to back.
    l0.push_back(9'h001); l0.push_back(9'h002); l0.push_back(9'h003);
    l1.push_back(9'h001); l1.push_back(9'h002); l1.push_back(9'h003);
    send();
    wait_idle();

    // Six held writes overflow a 4-deep FIFO; the sixth waits for a pop.
    for (int i = 0; i < 6; i++) begin
      l0.push_back(9'(8'h30 + i));
      l1.push_back(9'(7'h40 + i));
    end
    send();
    wait_idle();

    // Random traffic with varying write density.
    for (int blk = 0; blk < 8; blk++) begin
      int rate;
      case (blk % 4)
        0: rate = 60;
        1: rate = 2;
        2: rate = 15;
        default: rate = 0;
      endcase
      for (int k = 0; k < 120; k++) begin
        drive({$urandom_range(0, rate) == 0, $urandom_range(0, rate) == 0},
              9'($urandom), 9'($urandom), took);
      end
      drive(2'b00, 9'h000, 9'h000, took);
    end
    wait_idle();

    // Abandon a frame during data bit 3 with two characters still queued.
    l0.push_back(9'h0C3); l0.push_back(9'h05A); l0.push_back(9'h0E7);
    l1.push_back(9'h013); l1.push_back(9'h02C); l1.push_back(9'h055);
    send();
    g = 0;
    while (pos[0] < 4 * CPB0 + 1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("reach_bit3", 0, int'(g < 500), 1);
    check("queued_before_rst", 0, int'(level0), 2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_rst", 0, int'(serial), 3);
    check("act_after_rst", 0, int'(act), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an on-board transmit FIFO. Data width, parity mode, stop-bit count and bit period are configurable. A valid/ready write port lets the host queue several characters. Queued frames go out back-to-back with no idle gap, for use wherever a system block needs a buffered serial output line.

Parameters:
CLKS_PER_BIT, 87, clocks per serial bit (clock freq / baud); legal >= 2
DATA_BITS, 8, character width; legal 5..9
PARITY_EN, 0, 1 = append a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
STOP_BITS, 1, stop bits per frame; legal 1 or 2
FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
i_clk  in  1  clock; all logic on the rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_tx_dv  in  1  write strobe; a character is accepted on an edge where i_tx_dv=1 and o_tx_ready=1
i_tx_data  in  DATA_BITS  character to queue
o_tx_ready  out  1  FIFO not full
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
o_tx_serial  out  1  serial line, registered, idles high
o_tx_act  out  1  high while a frame is on the line
o_tx_done  out  1  one-clock pulse at the end of each frame

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - o_tx_serial=1, o_tx_act=0, o_tx_done=0
  - FIFO emptied, so o_fifo_level=0 and o_tx_ready=1
  - FSM goes to IDLE; bit counter and clock counter cleared
- Reset mid-frame: the frame is abandoned, the line goes high immediately and all queued data is discarded.
- o_tx_ready = (level != FIFO_DEPTH). It is combinational from the registered level.
- FIFO push and pop on the same edge are allowed whenever ready=1; the level is unchanged in that case. A write while full is ignored and leaves the FIFO unchanged.
- Frame format: start 0, then DATA_BITS bits LSB first, then an optional parity bit, then STOP_BITS stop 1s.
  - Each bit lasts exactly CLKS_PER_BIT clocks.
  - Frame length F = CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS).
- Parity bit = XOR of the data bits, XOR PARITY_ODD.
- FSM states are IDLE, START, DATA, PARITY and STOP. The clock counter runs 0..CLKS_PER_BIT-1.
  - IDLE: line high. If the FIFO is non-empty, pop the head into the shift register, set o_tx_serial<=0 and o_tx_act<=1, and go to START.
  - START -> DATA after CLKS_PER_BIT clocks.
  - DATA: bit index 0..DATA_BITS-1. After the last data bit go to PARITY if PARITY_EN=1, otherwise go to STOP.
  - PARITY -> STOP after CLKS_PER_BIT clocks.
  - STOP: counts STOP_BITS*CLKS_PER_BIT clocks.
- End of the final STOP clock:
  - o_tx_done<=1 for exactly one clock.
  - If the FIFO is non-empty, pop on that same edge, set o_tx_serial<=0 and go straight to START. o_tx_act stays 1 and there is no idle clock between frames.
  - Otherwise go to IDLE with o_tx_act<=0.
- Latency: a character accepted on edge N into an empty FIFO with the FSM in IDLE gives o_tx_serial=0 from edge N+1.
- o_tx_act is high for exactly F clocks per isolated frame, or continuously across back-to-back frames.
- Counter widths are $clog2 of their maximum count. No wrap occurs within legal parameters.

Test Plan:
- CLKS_PER_BIT=4, 8N1, write 0xA5 -> line low 4 clks, then 1,0,1,0,0,1,0,1 at 4 clks each, then high 4 clks. Total 40 clks, o_tx_act high 40 clks, single o_tx_done pulse at clock 40, line high afterwards.
- DATA_BITS=7, PARITY_EN=1, even parity, write 0x55 -> parity bit 0 and F=40. Repeat with PARITY_ODD=1 -> parity bit 1.
- Back-to-back, 8N1, CLKS_PER_BIT=4: write 0x01, 0x02, 0x03 on consecutive cycles -> 120 contiguous clocks of frames with no idle-high gap. o_tx_done pulses at clocks 40, 80 and 120. o_tx_act stays high throughout, then drops.
- FIFO full, FIFO_DEPTH=4: hold i_tx_dv with 6 distinct bytes -> 5 bytes accepted (the first is popped immediately) and level reaches 4. o_tx_ready goes low and the 6th byte is accepted only after the next pop. All 6 frames are transmitted in order.
- STOP_BITS=2, CLKS_PER_BIT=4, 8N1 otherwise, write 0xFF -> 4 low clocks then 40 high clocks, F=44, o_tx_done pulse at clock 44.
- Reset mid-frame: assert i_rst_n=0 during data bit 3 with 2 bytes queued -> o_tx_serial=1, o_tx_act=0 and o_fifo_level=0 with no clock edge needed. After release the line stays idle until a new write.
